fft_frame_ctrl: RTL and testbench
=================================

// Module: fft_frame_ctrl
// PURPOSE
//  Sequencer in front of fft_16. Collects the streaming audio sample stream into
//  16-sample frames in a ping-pong buffer. Presents each full frame to the FFT and
//  drives its start/done handshake. Latches the N magnitudes for the display path.
//  Sits between the ADC sample front end and the visualizer magnitude consumer.
// PARAMETERS
//  WIDTH        18    sample width; magnitudes are WIDTH+1 bits
//  N            16    frame length (samples per FFT); must equal FFT size
//  TIMEOUT_CYC  256   max cycles to wait for fft_done (used only with FFT_TIMEOUT_EN)
// PORTS
//  clk           in   1              system clock
//  rst_n         in   1              asynchronous active-low reset
//  sample_in     in   WIDTH          audio sample
//  sample_valid  in   1              sample_in valid this cycle
//  sample_ready  out  1              ctrl accepts sample (transfer = valid & ready)
//  fft_start     out  1              start request to fft_16
//  fft_done      in   1              fft_16 completion level
//  fft_samples   out  WIDTH x N      frame presented to fft_16 (unpacked [0:N-1])
//  fft_mag       in   (WIDTH+1) x N  fft_16 magnitude outputs
//  mag_out       out  (WIDTH+1) x N  latched magnitudes, stable between frames
//  mag_valid     out  1              1-cycle pulse: mag_out updated this cycle
//  fft_err       out  1              sticky timeout flag (FFT_TIMEOUT_EN only, else 0)
// BEHAVIOUR
//  Reset: all outputs 0 except sample_ready=1. Both banks empty, wr_bank=0, wr_idx=0, FSM IDLE.
//  Writer:
//   - Each transfer stores sample_in at bank[wr_bank][wr_idx]; wr_idx++.
//   - At wr_idx==N-1 the bank is marked full, wr_idx wraps to 0, and wr_bank toggles.
//   - sample_ready=0 while the bank at wr_bank is full; samples are never dropped or overwritten.
//  FSM (reader):
//   - IDLE: when a full bank exists -> START, rd_bank=that bank. fft_samples always = bank[rd_bank].
//   - START: fft_start=1 (held high). On fft_done=1: mag_out<=fft_mag, mag_valid=1 in the
//     next cycle, fft_start=0, bank[rd_bank] marked empty -> DRAIN.
//   - DRAIN: fft_start=0. Wait for fft_done=0, then -> IDLE.
//  Latency: FFT start is asserted 1 cycle after the bank fills, when the FSM is IDLE.
//  Simultaneous events:
//   - A bank fill and a bank release in the same cycle are both honoured.
//   - A release in the same cycle as a stall lifts the stall: sample_ready rises the next cycle.
//  Banks are consumed in fill order: 0,1,0,1...
//  rst_n low mid-frame or mid-FFT aborts immediately to the reset state; the partial frame is discarded.
// CONFIGURATION
//  FFT_TIMEOUT_EN defined:
//   - A counter runs in START. If it reaches TIMEOUT_CYC with no fft_done, then fft_start=0,
//     fft_err=1 (sticky until reset), the bank is released, no mag_valid, FSM -> DRAIN.
//  Not defined:
//   - No counter; START waits indefinitely; fft_err tied 0.
// STRUCTURE
//  fft_pkg:
//   - localparams FFT_N=16, SAMPLE_W=18
//   - typedef sample_t, mag_t
//   - enum ctrl_state_t {IDLE, START, DRAIN}
//  Sub-module frame_pingpong_buf: two banks, full flags, writer index, read mux.
//  The FSM stays in fft_frame_ctrl.
// TESTING
//  1. Reset, then 16 valid samples 1061,235,...,2556 back-to-back -> fft_start rises the cycle
//     after the 16th; fft_samples matches the input order.
//  2. Model done 4 cycles after start with fft_mag[k]=k+100 -> mag_valid one pulse, mag_out[k]=k+100,
//     start drops, FSM reaches IDLE after done falls.
//  3. Hold done low and stream 48 samples continuously -> sample_ready=0 after the 32nd accept.
//     Release done -> streaming resumes; no sample lost (check order across 3 frames).
//  4. Bank 1 fills in the same cycle done releases bank 0 -> no stall cycle; next start uses bank 1.
//  5. Drop rst_n at sample 9 and during START -> outputs return to reset values; next frame starts
//     at wr_idx 0, bank 0.
//  6. FFT_TIMEOUT_EN, TIMEOUT_CYC=8, done never asserted -> fft_err=1 at cycle 8 of START,
//     no mag_valid, and the bank is freed.

Source files
------------

// File: rtl/fft_pkg.sv
// Shared types and sizes for the fft_16 front-end sequencer.
package fft_pkg;

    localparam int FFT_N    = 16;
    localparam int SAMPLE_W = 18;

    typedef logic [SAMPLE_W-1:0] sample_t;
    typedef logic [SAMPLE_W:0]   mag_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DRAIN = 2'd2
    } ctrl_state_t;

endpackage

// File: rtl/frame_pingpong_buf.sv
// Two-bank sample store: writer fills banks alternately, reader selects one bank as a whole frame.
module frame_pingpong_buf
    import fft_pkg::*;
#(
    parameter int WIDTH = SAMPLE_W,
    parameter int N     = FFT_N
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] sample_in,
    input  logic             sample_valid,
    output logic             sample_ready,
    input  logic             rd_bank,
    input  logic             bank_release,
    output logic [1:0]       bank_full,
    output logic [WIDTH-1:0] rd_samples [0:N-1]
);
    localparam int IDX_W = $clog2(N);

    logic [WIDTH-1:0] mem [0:1][0:N-1];
    logic [1:0]       full_q;
    logic             wr_bank;
    logic [IDX_W-1:0] wr_idx;
    logic             push;
    logic             fill;
    logic [1:0]       fill_mask;
    logic [1:0]       rel_mask;

    // A full bank at the write pointer back-pressures; nothing is ever overwritten.
    assign sample_ready = !full_q[wr_bank];
    assign push         = sample_valid && sample_ready;
    assign fill         = push && (wr_idx == IDX_W'(N - 1));
    assign fill_mask    = fill ? (wr_bank ? 2'b10 : 2'b01) : 2'b00;
    assign rel_mask     = bank_release ? (rd_bank ? 2'b10 : 2'b01) : 2'b00;
    assign bank_full    = full_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            full_q  <= 2'b00;
            wr_bank <= 1'b0;
            wr_idx  <= '0;
            for (int b = 0; b < 2; b++) begin
                for (int i = 0; i < N; i++) begin
                    mem[b][i] <= '0;
                end
            end
        end else begin
            // Fill and release always target different banks, so both apply together.
            full_q <= (full_q & ~rel_mask) | fill_mask;
            if (push) begin
                mem[wr_bank][wr_idx] <= sample_in;
                wr_idx <= fill ? '0 : wr_idx + 1'b1;
                if (fill) begin
                    wr_bank <= ~wr_bank;
                end
            end
        end
    end

    always_comb begin
        for (int i = 0; i < N; i++) begin
            rd_samples[i] = mem[rd_bank][i];
        end
    end

endmodule

// File: rtl/fft_frame_ctrl.sv
// Frame sequencer in front of fft_16: ping-pong capture, start/done handshake, magnitude latch.
// Define FFT_TIMEOUT_EN to add an fft_done watchdog with a sticky fft_err flag.
module fft_frame_ctrl
    import fft_pkg::*;
#(
    parameter int WIDTH       = SAMPLE_W,
    parameter int N           = FFT_N,
    parameter int TIMEOUT_CYC = 256
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] sample_in,
    input  logic             sample_valid,
    output logic             sample_ready,
    output logic             fft_start,
    input  logic             fft_done,
    output logic [WIDTH-1:0] fft_samples [0:N-1],
    input  logic [WIDTH:0]   fft_mag [0:N-1],
    output logic [WIDTH:0]   mag_out [0:N-1],
    output logic             mag_valid,
    output logic             fft_err,
    output logic [1:0]       fsm_state
);
    ctrl_state_t state;
    ctrl_state_t state_next;
    logic        rd_bank;
    logic        bank_release;
    logic        capture;
    logic [1:0]  bank_full;

    frame_pingpong_buf #(.WIDTH(WIDTH), .N(N)) u_buf (
        .clk          (clk),
        .rst_n        (rst_n),
        .sample_in    (sample_in),
        .sample_valid (sample_valid),
        .sample_ready (sample_ready),
        .rd_bank      (rd_bank),
        .bank_release (bank_release),
        .bank_full    (bank_full),
        .rd_samples   (fft_samples)
    );

    assign fsm_state = state;

`ifdef FFT_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);
    logic [CNT_W-1:0] tmo_cnt;
    logic             timeout;
`endif

    always_comb begin
        state_next   = state;
        fft_start    = 1'b0;
        bank_release = 1'b0;
        capture      = 1'b0;
`ifdef FFT_TIMEOUT_EN
        timeout      = 1'b0;
`endif
        case (state)
            IDLE: begin
                if (bank_full[rd_bank]) state_next = START;
            end
            START: begin
                fft_start = 1'b1;
                if (fft_done) begin
                    capture      = 1'b1;
                    bank_release = 1'b1;
                    state_next   = DRAIN;
                end
`ifdef FFT_TIMEOUT_EN
                else if (tmo_cnt == CNT_W'(TIMEOUT_CYC - 1)) begin
                    timeout      = 1'b1;
                    bank_release = 1'b1;
                    state_next   = DRAIN;
                end
`endif
            end
            DRAIN: begin
                if (!fft_done) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // Banks are consumed strictly in fill order, so the read pointer simply alternates.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            rd_bank   <= 1'b0;
            mag_valid <= 1'b0;
            for (int k = 0; k < N; k++) begin
                mag_out[k] <= '0;
            end
        end else begin
            state     <= state_next;
            mag_valid <= capture;
            if (bank_release) rd_bank <= ~rd_bank;
            if (capture) begin
                for (int k = 0; k < N; k++) begin
                    mag_out[k] <= fft_mag[k];
                end
            end
        end
    end

`ifdef FFT_TIMEOUT_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tmo_cnt <= '0;
            fft_err <= 1'b0;
        end else begin
            tmo_cnt <= (state == START && state_next == START) ? tmo_cnt + 1'b1 : '0;
            if (timeout) fft_err <= 1'b1;
        end
    end
`else
    // Watchdog absent: the flag is a constant zero for any legal TIMEOUT_CYC.
    assign fft_err = (TIMEOUT_CYC < 0);
`endif

endmodule

// File: tb/tb_fft_frame_ctrl.sv
// Directed bench for fft_frame_ctrl: frame capture, handshake, back-pressure, reset abort, watchdog.
module tb_fft_frame_ctrl;
    import fft_pkg::*;

    localparam int W  = SAMPLE_W;
    localparam int NS = FFT_N;

    logic         clk;
    logic         rst_n;
    logic [W-1:0] sample_in;
    logic         sample_valid;
    logic         sample_ready;
    logic         fft_start;
    logic         fft_done;
    logic [W-1:0] fft_samples [0:NS-1];
    logic [W:0]   fft_mag [0:NS-1];
    logic [W:0]   mag_out [0:NS-1];
    logic         mag_valid;
    logic         fft_err;
    logic [1:0]   fsm_state;

    logic [W-1:0] exp_q[$];
    int           n_checks;
    int           n_errors;
    int           acc_cnt;

    sample_t tab [0:NS-1] = '{18'd1061, 18'd235, 18'd1790, 18'd412, 18'd3301, 18'd88,
                              18'd2047, 18'd999, 18'd1500, 18'd620, 18'd2890, 18'd17,
                              18'd3755, 18'd1204, 18'd431, 18'd2556};

    fft_frame_ctrl #(.WIDTH(W), .N(NS), .TIMEOUT_CYC(8)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .sample_in    (sample_in),
        .sample_valid (sample_valid),
        .sample_ready (sample_ready),
        .fft_start    (fft_start),
        .fft_done     (fft_done),
        .fft_samples  (fft_samples),
        .fft_mag      (fft_mag),
        .mag_out      (mag_out),
        .mag_valid    (mag_valid),
        .fft_err      (fft_err),
        .fsm_state    (fsm_state)
    );

    // clock / reset
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic tick2();
        @(posedge clk);
        #2;
    endtask

    task automatic do_reset();
        sample_valid = 1'b0;
        fft_done     = 1'b0;
        rst_n        = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
        tick();
        exp_q.delete();
    endtask

    // driver: hold the sample until it is accepted
    task automatic send(input logic [W-1:0] v, output int waits);
        sample_in    = v;
        sample_valid = 1'b1;
        waits        = 0;
        while (!sample_ready && waits < 200) begin
            tick();
            waits++;
        end
        if (!sample_ready) check("send_stuck", 32'(sample_ready), 1);
        tick();
        exp_q.push_back(v);
        acc_cnt++;
    endtask

    task automatic send_block(input int base, input int count);
        int w;
        for (int i = 0; i < count; i++) send(W'(base + i), w);
        sample_valid = 1'b0;
    endtask

    task automatic wait_start(input string tag, input int budget);
        int n;
        n = 0;
        while (!fft_start && n < budget) begin
            tick2();
            n++;
        end
        check(tag, 32'(fft_start), 1);
    endtask

    task automatic check_frame(input string tag);
        for (int k = 0; k < NS; k++) begin
            if (exp_q.size() == 0) check($sformatf("%s_qempty[%0d]", tag, k), 0, 1);
            else check($sformatf("%s[%0d]", tag, k), 32'(fft_samples[k]), 32'(exp_q.pop_front()));
        end
    endtask

    // fft_16 model: one-cycle done with mag[k] = base + k
    task automatic fft_complete(input string tag, input int base);
        for (int k = 0; k < NS; k++) fft_mag[k] = (W+1)'(base + k);
        fft_done = 1'b1;
        tick2();
        check({tag, "_mag_valid"}, 32'(mag_valid), 1);
        check({tag, "_mag0"}, 32'(mag_out[0]), 32'(base));
        check({tag, "_mag15"}, 32'(mag_out[NS-1]), 32'(base + NS - 1));
        fft_done = 1'b0;
        tick2();
    endtask

    initial begin
        int w;
        int total_w;
        n_checks     = 0;
        n_errors     = 0;
        acc_cnt      = 0;
        rst_n        = 1'b0;
        sample_in    = '0;
        sample_valid = 1'b0;
        fft_done     = 1'b0;
        for (int k = 0; k < NS; k++) fft_mag[k] = '0;
        tick();
        tick();
        check("rst_ready", 32'(sample_ready), 1);
        check("rst_start", 32'(fft_start), 0);
        check("rst_mag_valid", 32'(mag_valid), 0);
        check("rst_err", 32'(fft_err), 0);
        check("rst_state", 32'(fsm_state), 0);
        check("rst_samples0", 32'(fft_samples[0]), 0);
        check("rst_mag_out0", 32'(mag_out[0]), 0);
        rst_n = 1'b1;
        tick();

        // 1: first frame, start one cycle after the bank is full
        for (int i = 0; i < NS; i++) send(tab[i], w);
        sample_valid = 1'b0;
        check("t1_start_not_yet", 32'(fft_start), 0);
        tick();
        check("t1_start_rise", 32'(fft_start), 1);
        check_frame("t1_frame");

        // 2: done 4 cycles after start
        repeat (3) tick();
        check("t2_start_held", 32'(fft_start), 1);
        for (int k = 0; k < NS; k++) fft_mag[k] = (W+1)'(k + 100);
        fft_done = 1'b1;
        tick();
        check("t2_mag_valid", 32'(mag_valid), 1);
        check("t2_mag0", 32'(mag_out[0]), 100);
        check("t2_mag7", 32'(mag_out[7]), 107);
        check("t2_mag15", 32'(mag_out[15]), 115);
        check("t2_start_drop", 32'(fft_start), 0);
        check("t2_state_drain", 32'(fsm_state), 2);
        tick();
        check("t2_mag_valid_pulse", 32'(mag_valid), 0);
        check("t2_still_drain", 32'(fsm_state), 2);
        fft_done = 1'b0;
        tick();
        check("t2_state_idle", 32'(fsm_state), 0);
        check("t2_mag_hold", 32'(mag_out[3]), 103);

        // 3: back-pressure with done held low, 48 samples over 3 frames
        acc_cnt = 0;
        fork
            begin
                int wa;
                for (int i = 0; i < 48; i++) send(W'(3000 + i), wa);
                sample_valid = 1'b0;
            end
            begin
                automatic int n = 0;
                while (acc_cnt < 32 && n < 500) begin
                    tick2();
                    n++;
                end
                check("t3_stall_ready", 32'(sample_ready), 0);
                check("t3_start_held", 32'(fft_start), 1);
                repeat (5) tick2();
                check("t3_no_accept_stalled", 32'(acc_cnt), 32);
                check_frame("t3_f1");
                fft_complete("t3_f1", 1000);
                wait_start("t3_start_f2", 20);
                check_frame("t3_f2");
                fft_complete("t3_f2", 1100);
                wait_start("t3_start_f3", 100);
                check_frame("t3_f3");
                fft_complete("t3_f3", 1200);
            end
        join
        check("t3_all_accepted", 32'(acc_cnt), 48);

        // 4: bank 1 fills on the same edge that releases bank 0
        do_reset();
        total_w = 0;
        for (int i = 0; i < 2 * NS - 1; i++) begin
            send(W'(4000 + i), w);
            total_w += w;
        end
        check("t4_start_b0", 32'(fft_start), 1);
        check_frame("t4_b0");
        for (int k = 0; k < NS; k++) fft_mag[k] = (W+1)'(k + 200);
        fft_done = 1'b1;
        send(W'(4000 + 2 * NS - 1), w);
        total_w += w;
        sample_valid = 1'b0;
        check("t4_no_stall", 32'(sample_ready), 1);
        check("t4_total_waits", 32'(total_w), 0);
        check("t4_mag_valid", 32'(mag_valid), 1);
        check("t4_mag5", 32'(mag_out[5]), 205);
        fft_done = 1'b0;
        wait_start("t4_start_b1", 20);
        check_frame("t4_b1");
        fft_complete("t4_b1", 300);
        check("t4_idle", 32'(fsm_state), 0);

        // 5: reset mid-frame and mid-START
        do_reset();
        send_block(500, 9);
        #1;
        rst_n = 1'b0;
        #1;
        check("t5a_ready", 32'(sample_ready), 1);
        check("t5a_state", 32'(fsm_state), 0);
        check("t5a_samples0", 32'(fft_samples[0]), 0);
        check("t5a_mag_out0", 32'(mag_out[0]), 0);
        tick();
        rst_n = 1'b1;
        exp_q.delete();
        tick();
        send_block(600, NS);
        wait_start("t5b_start", 20);
        check_frame("t5b_frame");
        rst_n = 1'b0;
        #1;
        check("t5c_start", 32'(fft_start), 0);
        check("t5c_state", 32'(fsm_state), 0);
        check("t5c_ready", 32'(sample_ready), 1);
        check("t5c_samples3", 32'(fft_samples[3]), 0);
        check("t5c_mag_valid", 32'(mag_valid), 0);
        tick();
        rst_n = 1'b1;
        tick();

        // 6: fft_done never arrives
        send_block(700, NS);
        wait_start("t6_start", 20);
        check_frame("t6_frame");
`ifdef FFT_TIMEOUT_EN
        repeat (7) tick2();
        check("t6_err_before", 32'(fft_err), 0);
        check("t6_start_before", 32'(fft_start), 1);
        tick2();
        check("t6_err_set", 32'(fft_err), 1);
        check("t6_start_drop", 32'(fft_start), 0);
        check("t6_no_mag_valid", 32'(mag_valid), 0);
        check("t6_state_drain", 32'(fsm_state), 2);
        repeat (4) tick2();
        check("t6_bank_freed", 32'(fft_start), 0);
        check("t6_state_idle", 32'(fsm_state), 0);
        check("t6_err_sticky", 32'(fft_err), 1);
        check("t6_ready", 32'(sample_ready), 1);
`else
        repeat (20) tick2();
        check("t6_start_waits", 32'(fft_start), 1);
        check("t6_err_zero", 32'(fft_err), 0);
        fft_complete("t6_late", 400);
        check("t6_idle", 32'(fsm_state), 0);
`endif

        check("q_empty", 32'(exp_q.size()), 0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
